btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 8: consecutive synchronized clock cycles the input must hold a new level before the output follows; legal range 1..65535.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizer; legal range 2..4.
REQ-003 Counter width SHALL be derived internally as clog2(STABLE_CYCLES+1), minimum 1; it is not a port parameter.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0, takes effect immediately without a clock.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing button level.
REQ-007 btn_out  output  1  debounced button level, registered.
REQ-008 btn_rise  output  1  one-cycle registered pulse on each 0->1 transition of btn_out.

Function
REQ-009 btn_in SHALL pass through a SYNC_STAGES-deep flip-flop chain; only the last stage (btn_sync) is used by the remaining logic.
REQ-010 The block SHALL have two states, STABLE_LOW (btn_out=0) and STABLE_HIGH (btn_out=1); btn_out is the state bit.
REQ-011 On each rising edge where btn_sync equals btn_out, the stability counter SHALL clear to 0.
REQ-012 On each rising edge where btn_sync differs from btn_out and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 On a rising edge where btn_sync differs from btn_out and the counter equals STABLE_CYCLES-1, btn_out SHALL take btn_sync and the counter SHALL clear to 0.
REQ-014 A single cycle of btn_sync matching btn_out SHALL restart qualification from 0; partial counts are never retained.
REQ-015 Latency: for an input held steady, btn_out SHALL change on the (SYNC_STAGES+STABLE_CYCLES)-th rising edge, counting the first edge that samples the new level as edge 1 (default: 10th edge).
REQ-016 btn_rise SHALL be 1 for exactly the one cycle after the edge on which btn_out goes 0->1, and 0 otherwise; a 1->0 transition SHALL NOT pulse.
REQ-017 Any input pulse or glitch shorter than STABLE_CYCLES synchronized cycles SHALL NOT change btn_out or assert btn_rise.
REQ-018 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL NOT wrap.
REQ-019 Behaviour is symmetric: press (0->1) and release (1->0) use the same qualification rule and latency.

Reset
REQ-020 While reset=0: all synchronizer stages=0, counter=0, btn_out=0, btn_rise=0, state STABLE_LOW, regardless of clk or btn_in.
REQ-021 Reset assertion mid-qualification or in STABLE_HIGH SHALL abort immediately to the REQ-020 values; no btn_rise pulse results.
REQ-022 After reset deasserts with btn_in already high, full qualification per REQ-015 is required before btn_out=1.

Verification (default parameters, 10 ns clock)
REQ-023 Reset pulse low, btn_in=0 -> btn_out=0, btn_rise=0 asynchronously during reset and afterwards.
REQ-024 After reset, 14 ns burst of 1 ns toggles ending at 0, then 50 ns low -> btn_out and btn_rise remain 0 throughout.
REQ-025 btn_in steady high 200 ns -> btn_out rises on the 10th rising edge after the first edge sampling 1; btn_rise=1 for exactly one cycle after it; btn_out stays 1.
REQ-026 btn_out=1, btn_in low for 7 cycles then high again -> btn_out stays 1; counter cleared; no pulse.
REQ-027 btn_out=1, btn_in low steadily -> btn_out falls on the 10th edge; btn_rise stays 0.
REQ-028 reset asserted at counter=5 with btn_in high -> outputs 0 immediately; after release with btn_in still high, btn_out rises after a full 10-edge qualification.

Source files
------------

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// btn_debounce: synchronizes a raw, bouncing button level and only lets the
// debounced output follow once the synchronized level has held a new value for
// STABLE_CYCLES consecutive clocks. A one-cycle pulse marks each press.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - asynchronous, active-low reset
//   btn_in   - raw asynchronous button level
//   btn_out  - debounced level (registered; the FSM state bit itself)
//   btn_rise - registered one-cycle pulse on each 0->1 change of btn_out
module btn_debounce #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_rise
);

  localparam int unsigned CNT_W_RAW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] STABLE_LOW  = 1'b0;
  localparam logic [0:0] STABLE_HIGH = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [0:0]             state_q;
  logic [0:0]             state_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   rise_nxt;

  // Input synchronizer; only the last stage feeds the qualifier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // State, stability counter and press pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      btn_rise <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      btn_rise <= rise_nxt;
    end
  end

  // Next-state logic: any cycle that agrees with the current level restarts
  // qualification, so the counter never holds a partial count across a bounce.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    rise_nxt  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (btn_sync) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = STABLE_HIGH;
            cnt_nxt   = '0;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      STABLE_HIGH: begin
        if (!btn_sync) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = STABLE_LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
    endcase
  end

  assign btn_out = state_q[0];

endmodule

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
// Self-checking bench for btn_debounce (default parameters, 10 ns clock).
// Reference model: btn_out flips on an edge when the last STABLE_CYCLES
// synchronized samples (raw samples delayed by SYNC_STAGES edges) all differ
// from the current output.
module tb_btn_debounce;

  localparam int unsigned STABLE = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned HL     = SYNC + STABLE;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic btn_out;
  logic btn_rise;

  int n_checks = 0;
  int n_fail   = 0;

  bit hist[$];
  bit exp_out  = 1'b0;
  bit exp_rise = 1'b0;

  btn_debounce #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_out  (btn_out),
    .btn_rise (btn_rise)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model; hist[0] is the raw sample taken on the current edge.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        hist = {};
        for (int i = 0; i < int'(HL); i++) hist.push_back(1'b0);
        exp_out  = 1'b0;
        exp_rise = 1'b0;
      end else begin
        bit all_diff;
        hist.push_front(btn_in);
        hist = hist[0:HL-1];
        all_diff = 1'b1;
        for (int j = int'(SYNC); j < int'(HL); j++)
          if (hist[j] == exp_out) all_diff = 1'b0;
        exp_rise = all_diff && !exp_out;
        if (all_diff) exp_out = !exp_out;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_out", btn_out, exp_out);
      check("model_rise", btn_rise, exp_rise);
    end
  end

  // Hold btn_in at lvl from the next negedge, then check the output flips
  // exactly on edge 10 (counting the first edge sampling lvl as edge 1).
  task automatic expect_flip(input string name, input logic lvl, input logic from_lvl);
    @(negedge clk);
    btn_in = lvl;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      check({name, "_hold"}, btn_out, from_lvl);
      check({name, "_norise"}, btn_rise, 1'b0);
    end
    @(posedge clk); #1;
    check({name, "_edge10"}, btn_out, lvl);
    check({name, "_rise10"}, btn_rise, lvl);
    @(posedge clk); #1;
    check({name, "_after"}, btn_out, lvl);
    check({name, "_rise_off"}, btn_rise, 1'b0);
  endtask

  initial begin
    // Reset held: outputs low even with clock running and btn_in toggling.
    #2;
    check("rst_out", btn_out, 1'b0);
    check("rst_rise", btn_rise, 1'b0);
    btn_in = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("rst_hold_out", btn_out, 1'b0);
    check("rst_hold_rise", btn_rise, 1'b0);
    @(negedge clk);
    btn_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out", btn_out, 1'b0);

    // Short 1 ns toggle burst ending low, then 50 ns low: nothing moves.
    @(negedge clk);
    #0.5;
    for (int i = 0; i < 14; i++) begin
      btn_in = ~btn_in;
      #1;
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("burst_out", btn_out, 1'b0);
      check("burst_rise", btn_rise, 1'b0);
    end

    // Press held: rises on edge 10, single pulse, stays high.
    expect_flip("press", 1'b1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      check("press_stay", btn_out, 1'b1);
    end

    // 7-cycle dropout is rejected and leaves no partial count behind.
    @(negedge clk);
    btn_in = 1'b0;
    repeat (7) @(negedge clk);
    btn_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("dropout_out", btn_out, 1'b1);
      check("dropout_rise", btn_rise, 1'b0);
    end

    // Release held: falls on edge 10, no pulse (checked inside).
    expect_flip("release", 1'b0, 1'b1);

    // Reset while STABLE_HIGH clears outputs without a clock edge.
    expect_flip("press2", 1'b1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_high_out", btn_out, 1'b0);
    check("rst_high_rise", btn_rise, 1'b0);
    @(negedge clk);
    btn_in = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);

    // Reset at counter=5 with btn_in high, then full requalification.
    @(negedge clk);
    btn_in = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_mid_out", btn_out, 1'b0);
    check("rst_mid_rise", btn_rise, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      check("requal_hold", btn_out, 1'b0);
    end
    @(posedge clk); #1;
    check("requal_edge10", btn_out, 1'b1);
    check("requal_rise", btn_rise, 1'b1);

    // Randomized runs of random length, with occasional reset pulses.
    for (int r = 0; r < 600; r++) begin
      @(negedge clk);
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check("rand_rst_out", btn_out, 1'b0);
        check("rand_rst_rise", btn_rise, 1'b0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end

    repeat (HL + 2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
